seq_divider: RTL

Iterative restoring unsigned divider. It is the inverse operation of the team's combinational 4x4 array multiplier: it recovers a quotient and remainder from an 8-bit product-width dividend and a 4-bit divisor.
- Processes one quotient bit per clock cycle.
- Uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic datapath. Both results are registered and held stable until the next accepted operation.

---
 rtl/seq_divider_pkg.sv | 14 +
 rtl/seq_divider_div_step.sv | 21 ++
 rtl/seq_divider.sv | 116 +++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
// Shared arithmetic constants and types for the multiplier/divider datapath.
package seq_divider_pkg;
  localparam int DW    = 8;
  localparam int VW    = 4;
  localparam int CNT_W = $clog2(DW + 1);

  localparam logic [DW-1:0] DBZ_QUOTIENT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
module div_step
  import seq_divider_pkg::*;
(
  input  logic [VW:0]   p_in,
  input  logic          q_msb,
  input  logic [VW-1:0] divisor,
  output logic [VW:0]   p_out,
  output logic          q_bit
);

  logic [VW+1:0] shifted;
  logic [VW+1:0] divisor_ext;

  // Carrying p_in[VW] into the compare keeps it exact even for an out-of-range P.
  assign shifted     = {p_in, q_msb};
  assign divisor_ext = {2'b00, divisor};
  assign q_bit       = (shifted >= divisor_ext);
  assign p_out       = q_bit ? (shifted[VW:0] - divisor_ext[VW:0]) : shifted[VW:0];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start; operands captured on the accepting edge
//   RUN   | DW restoring iterations, one per cycle
//   DONE  | one-cycle done pulse; results already registered
module seq_divider
  import seq_divider_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  state_t           state_q, state_d;
  logic [DW-1:0]    q_q;
  logic [VW:0]      p_q;
  logic [VW-1:0]    d_q;
  logic [CNT_W-1:0] count_q;

  logic [VW:0]      p_next;
  logic             q_bit;
  logic [DW-1:0]    q_next;
  logic             last_step;

  div_step u_div_step (
    .p_in    (p_q),
    .q_msb   (q_q[DW-1]),
    .divisor (d_q),
    .p_out   (p_next),
    .q_bit   (q_bit)
  );

  assign q_next    = {q_q[DW-2:0], q_bit};
  assign last_step = (count_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q         <= '0;
      p_q         <= '0;
      d_q         <= '0;
      count_q     <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            q_q     <= dividend;
            d_q     <= divisor;
            p_q     <= '0;
            count_q <= CNT_W'(DW);
            if (divisor == '0) begin
              quotient    <= DBZ_QUOTIENT;
              remainder   <= '0;
              div_by_zero <= 1'b1;
            end else begin
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          q_q     <= q_next;
          p_q     <= p_next;
          count_q <= count_q - CNT_W'(1);
          // Results land on the edge that enters DONE so they are valid with the pulse.
          if (last_step) begin
            quotient  <= q_next;
            remainder <= p_next[VW-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
